// File: rtl/vetores_pkg.sv
// Shared constants and helpers for the byte <-> 32-bit word path.
package vetores_pkg;

    localparam int unsigned ORDEM_LITTLE  = 0;
    localparam int unsigned ORDEM_BIG     = 1;
    localparam int unsigned LARG_BYTE     = 8;
    localparam int unsigned BYTES_PALAVRA = 4;
    localparam int unsigned LARG_PALAVRA  = LARG_BYTE * BYTES_PALAVRA;

    localparam logic [BYTES_PALAVRA-1:0] MASCARA_CHEIA = 4'hF;

    // Write one byte into every lane selected by the one-hot lane vector.
    function automatic logic [LARG_PALAVRA-1:0] insere_byte(
        input logic [LARG_PALAVRA-1:0]  acc,
        input logic [BYTES_PALAVRA-1:0] lane_oh,
        input logic [LARG_BYTE-1:0]     dado
    );
        logic [LARG_PALAVRA-1:0] r;
        r = acc;
        for (int k = 0; k < int'(BYTES_PALAVRA); k++) begin
            if (lane_oh[k]) begin
                r[LARG_BYTE*k +: LARG_BYTE] = dado;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/montar_vetores_lane.sv
// Byte index to one-hot byte lane, honouring the configured byte order.
module montar_vetores_lane
    import vetores_pkg::*;
#(
    parameter int unsigned ORDEM = ORDEM_LITTLE
) (
    input  logic [1:0]               idx_i,
    output logic [BYTES_PALAVRA-1:0] lane_o
);

    // Little order fills lane 0 first; big order fills lane 3 first.
    always_comb begin
        lane_o = '0;
        if (ORDEM == ORDEM_BIG) begin
            lane_o[2'd3 - idx_i] = 1'b1;
        end else begin
            lane_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/montar_vetores.sv
// Byte-stream to 32-bit word assembler with lane mask and short-word flush.
module montar_vetores
    import vetores_pkg::*;
#(
    parameter int unsigned ORDEM     = ORDEM_LITTLE,
    parameter int unsigned LARG_CONT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LARG_BYTE-1:0]     in_dado,
    input  logic                     in_valido,
    output logic                     in_pronto,
    input  logic                     in_ultimo,
    output logic [LARG_PALAVRA-1:0]  out_dado,
    output logic [BYTES_PALAVRA-1:0] out_mascara,
    output logic                     out_valido,
    input  logic                     out_pronto,
    output logic [LARG_CONT-1:0]     palavras
);

    logic [LARG_PALAVRA-1:0]  acc_q, acc_d;
    logic [BYTES_PALAVRA-1:0] msk_q, msk_d;
    logic [1:0]               idx_q, idx_d;
    logic [LARG_PALAVRA-1:0]  out_dado_q, out_dado_d;
    logic [BYTES_PALAVRA-1:0] out_mascara_q, out_mascara_d;
    logic                     out_valido_q, out_valido_d;
    logic [LARG_CONT-1:0]     palavras_q, palavras_d;

    logic [BYTES_PALAVRA-1:0] lane_oh;
    logic [LARG_PALAVRA-1:0]  acc_merged;
    logic                     aceita;
    logic                     fecha;
    logic                     entrega;

    montar_vetores_lane #(
        .ORDEM (ORDEM)
    ) u_lane (
        .idx_i  (idx_q),
        .lane_o (lane_oh)
    );

    // A pending word blocks input unless it leaves in this same cycle.
    always_comb begin
        in_pronto  = !out_valido_q || out_pronto;
        aceita     = in_valido && in_pronto;
        entrega    = out_valido_q && out_pronto;
        // Lanes fill in a fixed order, so a full mask means this is the 4th byte.
        fecha      = in_ultimo || ((msk_q | lane_oh) == MASCARA_CHEIA);
        acc_merged = insere_byte(acc_q, lane_oh, in_dado);
    end

    // Next state: accumulate bytes, close words, count handshakes.
    always_comb begin
        acc_d         = acc_q;
        msk_d         = msk_q;
        idx_d         = idx_q;
        out_dado_d    = out_dado_q;
        out_mascara_d = out_mascara_q;
        out_valido_d  = out_valido_q;
        palavras_d    = palavras_q;

        if (entrega) begin
            palavras_d   = palavras_q + LARG_CONT'(1);
            out_valido_d = 1'b0;
        end

        if (aceita) begin
            if (fecha) begin
                // New word may replace one leaving this cycle: no bubble.
                out_dado_d    = acc_merged;
                out_mascara_d = msk_q | lane_oh;
                out_valido_d  = 1'b1;
                acc_d         = '0;
                msk_d         = '0;
                idx_d         = '0;
            end else begin
                acc_d = acc_merged;
                msk_d = msk_q | lane_oh;
                idx_d = idx_q + 2'd1;
            end
        end
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q         <= '0;
            msk_q         <= '0;
            idx_q         <= '0;
            out_dado_q    <= '0;
            out_mascara_q <= '0;
            out_valido_q  <= 1'b0;
            palavras_q    <= '0;
        end else begin
            acc_q         <= acc_d;
            msk_q         <= msk_d;
            idx_q         <= idx_d;
            out_dado_q    <= out_dado_d;
            out_mascara_q <= out_mascara_d;
            out_valido_q  <= out_valido_d;
            palavras_q    <= palavras_d;
        end
    end

    assign out_dado    = out_dado_q;
    assign out_mascara = out_mascara_q;
    assign out_valido  = out_valido_q;
    assign palavras    = palavras_q;

endmodule
